// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared pipeline codes and EX/MEM register layout
package ex_mem_reg_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9
  } alu_sel_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_GEZ  = 2'd3
  } branch_type_t;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_TRAP   = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] epc;
  } mem_regs_t;

  // A bubble clears every field except the exception PC, which the caller supplies.
  function automatic mem_regs_t bubble(input logic [31:0] epc);
    mem_regs_t r;
    r     = '0;
    r.epc = epc;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_reg_branch_cmp.sv
// rtl/ex_mem_reg_branch_cmp.sv - branch condition evaluation from ALU flags
module branch_cmp
  import ex_mem_reg_pkg::*;
(
  input  branch_type_t br_type,
  input  logic         zero,
  input  logic         ge_zero,
  output logic         taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_NONE: taken = 1'b0;
      BR_EQ:   taken = zero;
      BR_NE:   taken = ~zero;
      BR_GEZ:  taken = ge_zero;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with branch resolve and overflow trap
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        exc_ack,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_ge_zero,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_branch_type,
  input  logic [31:0] in_branch_target,
  input  logic        in_ovf_trap,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_alu,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_mem_read,
  output logic        out_mem_write,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        exc_pending,
  output logic [31:0] exc_epc
);

  state_t    state_q, state_d;
  mem_regs_t regs_q, regs_d;
  logic      br_taken;
  logic      trap_hit;

  branch_cmp u_branch_cmp (
    .br_type (branch_type_t'(in_branch_type)),
    .zero    (alu_zero),
    .ge_zero (alu_ge_zero),
    .taken   (br_taken)
  );

  assign trap_hit = in_valid & in_ovf_trap & alu_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    case (state_q)
      ST_NORMAL: begin
        if (flush) begin
          regs_d = bubble(regs_q.epc);
        end else if (stall) begin
          // Held branches must not redirect fetch a second time.
          regs_d.branch_taken = 1'b0;
        end else if (trap_hit) begin
          regs_d  = bubble(in_pc);
          state_d = ST_TRAP;
        end else begin
          regs_d.valid         = in_valid;
          regs_d.pc            = in_pc;
          regs_d.alu           = alu_out;
          regs_d.store_data    = in_store_data;
          regs_d.rd            = in_rd;
          regs_d.reg_write     = in_reg_write;
          regs_d.mem_read      = in_mem_read;
          regs_d.mem_write     = in_mem_write;
          regs_d.branch_taken  = in_valid & br_taken;
          regs_d.branch_target = in_branch_target;
        end
      end
      ST_TRAP: begin
        // The bubble loaded on entry is held; the ack-cycle input is dropped.
        if (exc_ack) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign exc_pending    = (state_q == ST_TRAP);
  assign out_valid      = regs_q.valid;
  assign out_pc         = regs_q.pc;
  assign out_alu        = regs_q.alu;
  assign out_store_data = regs_q.store_data;
  assign out_rd         = regs_q.rd;
  assign out_reg_write  = regs_q.reg_write;
  assign out_mem_read   = regs_q.mem_read;
  assign out_mem_write  = regs_q.mem_write;
  assign branch_taken   = regs_q.branch_taken;
  assign branch_target  = regs_q.branch_target;
  assign exc_epc        = regs_q.epc;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - directed and random scoreboard bench for ex_mem_reg
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush, exc_ack;
  logic        in_valid, alu_zero, alu_overflow, alu_ge_zero;
  logic [31:0] in_pc, alu_out, in_store_data, in_branch_target;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_mem_read, in_mem_write, in_ovf_trap;
  logic [1:0]  in_branch_type;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic        branch_taken, exc_pending;
  logic [31:0] out_pc, out_alu, out_store_data, branch_target, exc_epc;
  logic [4:0]  out_rd;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        bt;
    logic [31:0] btgt;
    logic        pend;
    logic [31:0] epc;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .exc_ack(exc_ack),
    .in_valid(in_valid), .in_pc(in_pc), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_ge_zero(alu_ge_zero),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_branch_type(in_branch_type), .in_branch_target(in_branch_target),
    .in_ovf_trap(in_ovf_trap), .out_valid(out_valid), .out_pc(out_pc),
    .out_alu(out_alu), .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .exc_pending(exc_pending), .exc_epc(exc_epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    in_valid = 1'b0; in_pc = '0; alu_out = '0; alu_zero = 1'b0;
    alu_overflow = 1'b0; alu_ge_zero = 1'b0; in_store_data = '0; in_rd = '0;
    in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_branch_type = 2'd0; in_branch_target = '0; in_ovf_trap = 1'b0;
  endtask

  // Reference behaviour, evaluated on the inputs about to be sampled.
  task automatic model_step();
    logic take;
    case (in_branch_type)
      2'd1:    take = alu_zero;
      2'd2:    take = !alu_zero;
      2'd3:    take = alu_ge_zero;
      default: take = 1'b0;
    endcase
    if (rst) begin
      m = '0;
    end else if (m.pend) begin
      if (exc_ack) m.pend = 1'b0;
    end else if (flush) begin
      m = '{valid: 1'b0, pc: '0, alu: '0, sd: '0, rd: '0, rw: 1'b0, mr: 1'b0,
            mw: 1'b0, bt: 1'b0, btgt: '0, pend: 1'b0, epc: m.epc};
    end else if (stall) begin
      m.bt = 1'b0;
    end else if (in_valid && in_ovf_trap && alu_overflow) begin
      m = '{valid: 1'b0, pc: '0, alu: '0, sd: '0, rd: '0, rw: 1'b0, mr: 1'b0,
            mw: 1'b0, bt: 1'b0, btgt: '0, pend: 1'b1, epc: in_pc};
    end else begin
      m = '{valid: in_valid, pc: in_pc, alu: alu_out, sd: in_store_data, rd: in_rd,
            rw: in_reg_write, mr: in_mem_read, mw: in_mem_write,
            bt: in_valid && take, btgt: in_branch_target, pend: 1'b0, epc: m.epc};
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out_valid", 32'(out_valid), 32'(e.valid));
    chk("out_pc", out_pc, e.pc);
    chk("out_alu", out_alu, e.alu);
    chk("out_store_data", out_store_data, e.sd);
    chk("out_rd", 32'(out_rd), 32'(e.rd));
    chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
    chk("out_mem_read", 32'(out_mem_read), 32'(e.mr));
    chk("out_mem_write", 32'(out_mem_write), 32'(e.mw));
    chk("branch_taken", 32'(branch_taken), 32'(e.bt));
    chk("branch_target", branch_target, e.btgt);
    chk("exc_pending", 32'(exc_pending), 32'(e.pend));
    chk("exc_epc", exc_epc, e.epc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    idle_inputs();
    // Reset with garbage on every input
    rst = 1'b1; stall = 1'b1; flush = 1'b1; exc_ack = 1'b1; in_valid = 1'b1;
    alu_out = 32'hdead_beef; in_ovf_trap = 1'b1; alu_overflow = 1'b1;
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pending", 32'(exc_pending), 32'd0);
    idle_inputs();
    cycle();

    // Plain load
    in_valid = 1'b1; alu_out = 32'h0000_0005; in_rd = 5'd3; in_reg_write = 1'b1;
    in_pc = 32'h0040_0000;
    cycle();
    chk("load_alu", out_alu, 32'd5);
    chk("load_rd", 32'(out_rd), 32'd3);
    chk("load_rw", 32'(out_reg_write), 32'd1);
    chk("load_valid", 32'(out_valid), 32'd1);

    // BNE taken then two stall cycles
    idle_inputs();
    in_valid = 1'b1; in_branch_type = 2'd2; alu_zero = 1'b0;
    in_branch_target = 32'h0040_0020; in_pc = 32'h0040_0004;
    cycle();
    chk("bne_taken", 32'(branch_taken), 32'd1);
    stall = 1'b1; in_branch_target = 32'h1111_1111; alu_out = 32'h2222_2222;
    cycle();
    chk("stall1_taken", 32'(branch_taken), 32'd0);
    chk("stall1_target", branch_target, 32'h0040_0020);
    cycle();
    chk("stall2_taken", 32'(branch_taken), 32'd0);
    chk("stall2_target", branch_target, 32'h0040_0020);

    // Remaining branch types, including an invalid taken branch
    idle_inputs(); in_valid = 1'b1; in_branch_type = 2'd1; alu_zero = 1'b1; cycle();
    chk("beq_taken", 32'(branch_taken), 32'd1);
    alu_zero = 1'b0; cycle();
    chk("beq_not", 32'(branch_taken), 32'd0);
    in_branch_type = 2'd3; alu_ge_zero = 1'b1; cycle();
    chk("bgez_taken", 32'(branch_taken), 32'd1);
    alu_ge_zero = 1'b0; cycle();
    in_branch_type = 2'd0; alu_zero = 1'b1; alu_ge_zero = 1'b1; cycle();
    chk("none_not", 32'(branch_taken), 32'd0);
    in_valid = 1'b0; in_branch_type = 2'd2; alu_zero = 1'b0; cycle();
    chk("inval_not", 32'(branch_taken), 32'd0);

    // flush beats stall; flush beats a trapping input
    idle_inputs(); in_valid = 1'b1; in_reg_write = 1'b1; alu_out = 32'h77; cycle();
    flush = 1'b1; stall = 1'b1; cycle();
    chk("flush_stall_valid", 32'(out_valid), 32'd0);
    stall = 1'b0; in_ovf_trap = 1'b1; alu_overflow = 1'b1; cycle();
    chk("flush_trap_pend", 32'(exc_pending), 32'd0);

    // Unsigned add ignores overflow
    idle_inputs(); in_valid = 1'b1; alu_overflow = 1'b1; alu_out = 32'h8000_0000; cycle();
    chk("unsigned_alu", out_alu, 32'h8000_0000);
    chk("unsigned_pend", 32'(exc_pending), 32'd0);

    // Trap, ignored inputs, then ack with squashed input
    idle_inputs(); in_valid = 1'b1; in_pc = 32'h0040_0010; in_ovf_trap = 1'b1;
    alu_overflow = 1'b1; in_reg_write = 1'b1; cycle();
    chk("trap_pend", 32'(exc_pending), 32'd1);
    chk("trap_epc", exc_epc, 32'h0040_0010);
    chk("trap_valid", 32'(out_valid), 32'd0);
    idle_inputs(); in_valid = 1'b1; in_reg_write = 1'b1; in_pc = 32'h0040_0014;
    in_branch_type = 2'd2; cycle();
    flush = 1'b1; stall = 1'b1; cycle();
    chk("trap_hold_epc", exc_epc, 32'h0040_0010);
    flush = 1'b0; stall = 1'b0; exc_ack = 1'b1; in_pc = 32'h0040_0018; cycle();
    chk("ack_pend", 32'(exc_pending), 32'd0);
    chk("ack_squash", 32'(out_valid), 32'd0);
    exc_ack = 1'b1; in_pc = 32'h0040_001c; alu_out = 32'h99; cycle();
    chk("ack_normal_load", out_alu, 32'h99);

    // Reset mid-trap
    idle_inputs(); in_valid = 1'b1; in_ovf_trap = 1'b1; alu_overflow = 1'b1;
    in_pc = 32'h0040_0030; cycle();
    idle_inputs(); rst = 1'b1; cycle();
    chk("rst_trap_pend", 32'(exc_pending), 32'd0);
    chk("rst_trap_epc", exc_epc, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      in_valid = 1'($urandom_range(0, 1));
      in_pc = $urandom; alu_out = $urandom; in_store_data = $urandom;
      in_branch_target = $urandom; in_rd = 5'($urandom_range(0, 31));
      alu_zero = 1'($urandom_range(0, 1)); alu_ge_zero = 1'($urandom_range(0, 1));
      alu_overflow = ($urandom_range(0, 2) == 0); in_ovf_trap = ($urandom_range(0, 2) == 0);
      in_reg_write = 1'($urandom_range(0, 1)); in_mem_read = 1'($urandom_range(0, 1));
      in_mem_write = 1'($urandom_range(0, 1)); in_branch_type = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL expose control inputs: stall  in  1  hold all registers; flush  in  1  load a bubble; exc_ack  in  1  trap handler accepted.
REQ-004 SHALL expose EX inputs: in_valid 1; in_pc 32; alu_out 32; alu_zero 1; alu_overflow 1; alu_ge_zero 1; in_store_data 32; in_rd 5; in_reg_write 1; in_mem_read 1; in_mem_write 1; in_branch_type 2; in_branch_target 32; in_ovf_trap 1 (signed add, traps on overflow).
REQ-005 SHALL expose MEM outputs: out_valid 1; out_pc 32; out_alu 32; out_store_data 32; out_rd 5; out_reg_write 1; out_mem_read 1; out_mem_write 1; branch_taken 1; branch_target 32; exc_pending 1; exc_epc 32.

Function
REQ-006 SHALL be a single-stage register: EX inputs sampled on edge N appear on outputs after edge N (latency 1).
REQ-007 SHALL use priority rst > TRAP state > flush > stall > load.
REQ-008 SHALL, when stall=1 and flush=0 in NORMAL, hold every output register unchanged.
REQ-009 SHALL, when flush=1 in NORMAL, load a bubble: out_valid, out_reg_write, out_mem_read, out_mem_write, branch_taken = 0; data fields don't-care but zeroed.
REQ-010 SHALL resolve branches on load: type NONE=0 never; BEQ=1 taken iff alu_zero; BNE=2 taken iff !alu_zero; BGEZ=3 taken iff alu_ge_zero; branch_taken registered only if in_valid=1.
REQ-011 SHALL register branch_target from in_branch_target on every load.
REQ-012 SHALL assert branch_taken for exactly one cycle per taken branch: when stall holds the register, branch_taken SHALL drop to 0 after its first cycle while other fields hold.
REQ-013 SHALL implement FSM states NORMAL and TRAP; reset state NORMAL.
REQ-014 SHALL detect trap when in NORMAL, flush=0, stall=0, in_valid=1, in_ovf_trap=1, alu_overflow=1.
REQ-015 SHALL on trap: load a bubble (REQ-009 fields), set exc_epc=in_pc, move to TRAP.
REQ-016 SHALL in TRAP: exc_pending=1, exc_epc held, out_valid and all write/branch enables 0, all EX inputs ignored including stall and flush.
REQ-017 SHALL in TRAP with exc_ack=1 return to NORMAL on that edge; input presented that cycle is squashed, not loaded.
REQ-018 SHALL ignore exc_ack in NORMAL.
REQ-019 SHALL ignore alu_overflow when in_ovf_trap=0 (unsigned add), loading normally.
REQ-020 SHALL drive exc_pending combinationally from state (1 iff TRAP).

Reset
REQ-021 SHALL on rst=1 at a clock edge set state NORMAL and all outputs 0, overriding stall, flush, exc_ack and a pending trap.
REQ-022 SHALL accept rst mid-TRAP or mid-stall with identical result to REQ-021.

Structure
REQ-023 SHALL take branch-type codes (BR_NONE, BR_EQ, BR_NE, BR_GEZ) and FSM state codes from the shared defines file alongside the ALU select codes.
REQ-024 SHALL place branch condition evaluation in one combinational sub-module branch_cmp (inputs type, zero, ge_zero; output taken).
REQ-025 SHALL contain no combinational path from EX inputs to MEM outputs.

Verification
REQ-026 Load: in_valid=1, alu_out=0x0000_0005, in_rd=3, in_reg_write=1 -> next cycle out_alu=5, out_rd=3, out_reg_write=1, out_valid=1.
REQ-027 Branch: BNE with alu_zero=0, target 0x0040_0020, then stall 2 cycles -> branch_taken=1 one cycle only, branch_target=0x0040_0020 held 3 cycles.
REQ-028 Trap: in_pc=0x0040_0010, in_ovf_trap=1, alu_overflow=1 -> out_valid=0, exc_pending=1, exc_epc=0x0040_0010; further valid inputs ignored until exc_ack; cycle after ack exc_pending=0.
REQ-029 Unsigned add: in_ovf_trap=0, alu_overflow=1, alu_out=0x8000_0000 -> loaded normally, exc_pending stays 0.
REQ-030 Priority: flush=1 and stall=1 together -> bubble; trapping input with flush=1 -> bubble, no trap.
REQ-031 Reset: rst=1 during TRAP with exc_ack=0 -> next cycle exc_pending=0, all outputs 0.
